sopc_mem_arbiter: RTL and testbench
===================================

// Module: sopc_mem_arbiter
// PURPOSE
//  Shares one single-port 32-bit memory bus between the CPU fetch port (IF) and the load/store port (D).
//  Sits inside my_mips_sopc between the core and the unified RAM, and raises stall_req to the pipeline control.
//  Grants the bus to one requester per transaction, holds stall_req while any request is unserved,
//  and forces a bus-error completion when the memory does not answer.
// PARAMETERS
//  MAX_D_BURST  4   consecutive D grants allowed while if_req is pending; the next grant goes to IF
//  TIMEOUT      64  cycles in a grant state without m_ack before a forced error completion (>=2)
// PORTS
//  clk       in   1   single clock, all logic on rising edge
//  rst       in   1   synchronous reset, active-low (0 = reset)
//  if_req    in   1   fetch request, held until if_ack
//  if_addr   in   32  fetch address
//  if_rdata  out  32  fetch data, valid while if_ack=1
//  if_ack    out  1   one-cycle completion pulse for IF
//  d_req     in   1   data request, held until d_ack
//  d_we      in   1   1 = write
//  d_sel     in   4   byte enables
//  d_addr    in   32  data address
//  d_wdata   in   32  write data
//  d_rdata   out  32  read data, valid while d_ack=1
//  d_ack     out  1   one-cycle completion pulse for D
//  bus_err   out  1   high together with an ack when that completion was a timeout
//  m_req     out  1   memory request, held until m_ack
//  m_we, m_sel, m_addr, m_wdata  out  1/4/32/32  memory command (registered at grant)
//  m_rdata   in   32  memory read data, sampled when m_ack=1
//  m_ack     in   1   memory completion (>=1 cycle after m_req rises)
//  stall_req out  1   comb: (if_req & ~if_ack) | (d_req & ~d_ack)
// BEHAVIOUR
//  Reset (rst=0 at an edge): state IDLE. All registered outputs 0, including m_req and the ack/err outputs.
//   Burst and timeout counters are 0. An in-flight memory access is abandoned and its m_ack is ignored.
//  States: IDLE, GNT_IF, GNT_D, DONE.
//  IDLE arbitration:
//   - d_req & (~if_req | burst<MAX_D_BURST) -> GNT_D.
//   - else if_req -> GNT_IF.
//   - else stay in IDLE.
//  On entering GNT_x, latch the command into the m_* registers:
//   - IF: m_we=0, m_sel=4'hF, m_addr=if_addr.
//   - D: d_we/d_sel/d_addr/d_wdata.
//   Also set m_req=1 and timeout=0.
//  GNT_x while m_ack=0: hold the command; timeout+1.
//   - When timeout reaches TIMEOUT-1 -> DONE with rdata=32'h0 and bus_err=1.
//  GNT_x with m_ack=1 -> DONE; x_rdata <= m_rdata (IF and writes also capture it), bus_err=0.
//   m_req is 0 from the DONE cycle onward.
//  DONE: exactly one of if_ack/d_ack is 1 for this single cycle. Both req inputs are ignored. Next state is IDLE.
//   The requester must drop its req in the DONE cycle; a req still high in the next IDLE cycle is a new request.
//  Latency: req seen in IDLE at cycle 0 -> m_req=1 at cycle 1 -> m_ack at cycle k -> ack at k+1 -> IDLE at k+2.
//  Burst counter:
//   - +1 on each GNT_D entry while if_req=1, saturating at MAX_D_BURST.
//   - Cleared on GNT_IF entry, or on GNT_D entry with if_req=0.
//  Simultaneous requests: D wins unless burst=MAX_D_BURST, in which case IF wins.
//  if_ack and d_ack are never both 1. Ack without a preceding grant is illegal.
//  Requests that change address while waiting have no effect after grant (the command is latched).
// STRUCTURE
//  defines.v (shared): state encodings ARB_IDLE/ARB_GNT_IF/ARB_GNT_D/ARB_DONE (2-bit), ZERO_WORD, bus widths.
//   The RTL uses defines.v enable/disable macros, with rst active-low.
//  One sub-module: arb_timeout_cnt (clear, enable, terminal-count flag) for the TIMEOUT counter.
//   Arbitration and the FSM are kept inline.
// TESTING
//  1 IF read: if_req=1, if_addr=0x100, m_ack 2 cycles after m_req, m_rdata=0x3C010001
//     -> m_addr=0x100 m_sel=F, if_ack 1 cycle with if_rdata=0x3C010001, bus_err=0.
//  2 Both req every cycle, MAX_D_BURST=4, instant m_ack
//     -> grant order D,D,D,D,IF,D,...; stall_req high until each ack.
//  3 D write d_addr=0x40 d_wdata=0xDEADBEEF d_sel=0011
//     -> m_we=1 with matching m_* fields held stable until m_ack; d_ack pulse.
//  4 Memory silent, TIMEOUT=64 -> m_req drops, ack + bus_err=1 and rdata=0 exactly 64 cycles after grant.
//  5 rst=0 asserted mid-GNT_D -> next cycle all outputs 0 and state IDLE; a late m_ack produces no ack.
//  6 req held high through DONE -> exactly one ack, then a fresh grant cycle in IDLE (back-to-back transactions).

Source files
------------

// File: rtl/sopc_mem_arbiter_pkg.sv
// Shared types and constants for the IF / D memory bus arbiter.
package sopc_mem_arbiter_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int SEL_W  = 4;

   localparam logic [DATA_W-1:0] ZERO_WORD = '0;

   // Reset is active-low; enable/disable levels used for control flops.
   localparam logic RST_ACTIVE = 1'b0;
   localparam logic ENABLE     = 1'b1;
   localparam logic DISABLE    = 1'b0;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_GNT_IF = 2'd1,
      ARB_GNT_D  = 2'd2,
      ARB_DONE   = 2'd3
   } arb_state_e;

   // Memory command as latched at grant time.
   typedef struct packed {
      logic              we;
      logic [SEL_W-1:0]  sel;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } mem_cmd_t;

   // Instruction fetches are always full-word reads.
   function automatic mem_cmd_t fetch_cmd(input logic [ADDR_W-1:0] addr);
      mem_cmd_t c;
      c.we    = DISABLE;
      c.sel   = '1;
      c.addr  = addr;
      c.wdata = ZERO_WORD;
      return c;
   endfunction

endpackage

// File: rtl/sopc_mem_arbiter_timeout_cnt.sv
// Cycle counter for a memory grant; flags the last cycle before a forced error.
module arb_timeout_cnt
   import sopc_mem_arbiter_pkg::*;
#(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int CW = $clog2(TIMEOUT);

   logic [CW-1:0] cnt_q, cnt_d;

   // Clear dominates; counting stops at the terminal value.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && !tc) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   assign tc = (cnt_q == CW'(TIMEOUT - 1));

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst == RST_ACTIVE) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/sopc_mem_arbiter.sv
// Arbiter sharing one memory bus between the fetch port and the load/store port.
module sopc_mem_arbiter
   import sopc_mem_arbiter_pkg::*;
#(
   parameter int MAX_D_BURST = 4,
   parameter int TIMEOUT     = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [SEL_W-1:0]  d_sel,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ack,
   output logic              bus_err,
   output logic              m_req,
   output logic              m_we,
   output logic [SEL_W-1:0]  m_sel,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic [DATA_W-1:0] m_rdata,
   input  logic              m_ack,
   output logic              stall_req
);

   localparam int BW = $clog2(MAX_D_BURST + 1);
   localparam logic [BW-1:0] BURST_MAX = BW'(MAX_D_BURST);

   arb_state_e        state_q, state_d;
   logic [BW-1:0]     burst_q, burst_d;
   mem_cmd_t          cmd_q, cmd_d;
   logic              m_req_q, m_req_d;
   logic              if_ack_q, if_ack_d;
   logic              d_ack_q, d_ack_d;
   logic              bus_err_q, bus_err_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

   logic in_grant;
   logic tmo_tc;

   assign in_grant = (state_q == ARB_GNT_IF) || (state_q == ARB_GNT_D);

   // The timer sits at zero outside a grant, so it starts fresh on every grant entry.
   arb_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk (clk),
      .rst (rst),
      .clr (!in_grant),
      .en  (in_grant && !m_ack),
      .tc  (tmo_tc)
   );

   // Next-state, arbitration, command latch and completion outputs.
   always_comb begin
      state_d    = state_q;
      burst_d    = burst_q;
      cmd_d      = cmd_q;
      m_req_d    = m_req_q;
      if_ack_d   = DISABLE;
      d_ack_d    = DISABLE;
      bus_err_d  = DISABLE;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;

      unique case (state_q)
         ARB_IDLE: begin
            // D wins a tie unless it has used up its burst allowance.
            if (d_req && (!if_req || (burst_q < BURST_MAX))) begin
               state_d = ARB_GNT_D;
               cmd_d   = '{we: d_we, sel: d_sel, addr: d_addr, wdata: d_wdata};
               m_req_d = ENABLE;
               if (!if_req) begin
                  burst_d = '0;
               end else if (burst_q != BURST_MAX) begin
                  burst_d = burst_q + 1'b1;
               end
            end else if (if_req) begin
               state_d = ARB_GNT_IF;
               cmd_d   = fetch_cmd(if_addr);
               m_req_d = ENABLE;
               burst_d = '0;
            end
         end

         ARB_GNT_IF, ARB_GNT_D: begin
            // A real answer takes priority over the timeout on the same cycle.
            if (m_ack || tmo_tc) begin
               state_d   = ARB_DONE;
               m_req_d   = DISABLE;
               bus_err_d = !m_ack;
               if (state_q == ARB_GNT_IF) begin
                  if_ack_d   = ENABLE;
                  if_rdata_d = m_ack ? m_rdata : ZERO_WORD;
               end else begin
                  d_ack_d   = ENABLE;
                  d_rdata_d = m_ack ? m_rdata : ZERO_WORD;
               end
            end
         end

         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst == RST_ACTIVE) begin
         state_q    <= ARB_IDLE;
         burst_q    <= '0;
         cmd_q      <= '0;
         m_req_q    <= DISABLE;
         if_ack_q   <= DISABLE;
         d_ack_q    <= DISABLE;
         bus_err_q  <= DISABLE;
         if_rdata_q <= ZERO_WORD;
         d_rdata_q  <= ZERO_WORD;
      end else begin
         state_q    <= state_d;
         burst_q    <= burst_d;
         cmd_q      <= cmd_d;
         m_req_q    <= m_req_d;
         if_ack_q   <= if_ack_d;
         d_ack_q    <= d_ack_d;
         bus_err_q  <= bus_err_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
      end
   end

   assign m_req     = m_req_q;
   assign m_we      = cmd_q.we;
   assign m_sel     = cmd_q.sel;
   assign m_addr    = cmd_q.addr;
   assign m_wdata   = cmd_q.wdata;
   assign if_ack    = if_ack_q;
   assign d_ack     = d_ack_q;
   assign bus_err   = bus_err_q;
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign stall_req = (if_req & ~if_ack_q) | (d_req & ~d_ack_q);

endmodule

// File: tb/tb_sopc_mem_arbiter.sv
// Directed bench for sopc_mem_arbiter with a transaction-schedule reference model.
module tb_sopc_mem_arbiter;

   localparam int MAXB = 4;
   localparam int TMO  = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic [31:0] if_rdata;
   logic        if_ack;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [3:0]  d_sel = '0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic [31:0] d_rdata;
   logic        d_ack;
   logic        bus_err;
   logic        m_req;
   logic        m_we;
   logic [3:0]  m_sel;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [31:0] m_rdata = '0;
   logic        m_ack = 1'b0;
   logic        stall_req;

   always #5 clk = ~clk;

   sopc_mem_arbiter #(.MAX_D_BURST(MAXB), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .d_req(d_req), .d_we(d_we), .d_sel(d_sel), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ack(d_ack), .bus_err(bus_err),
      .m_req(m_req), .m_we(m_we), .m_sel(m_sel), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .m_ack(m_ack), .stall_req(stall_req)
   );

   int n = 0;
   int passes = 0;
   int total = 0;

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, n);
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      total++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, n);
   endtask

   // ---------------- memory responder ----------------
   // Answers mem_lat cycles after m_req rises (0 = same cycle); negative = silent.
   int          mem_lat = 1;
   logic [31:0] mem_rdata = '0;
   bit          force_ack = 1'b0;
   int          mcnt = 0;

   always @(negedge clk) begin
      if (m_req !== 1'b1) begin
         mcnt    = 0;
         m_ack   = force_ack;
         m_rdata = 32'h0BAD_0000;
      end else begin
         m_ack   = force_ack || (mem_lat >= 0 && mcnt == mem_lat);
         m_rdata = m_ack ? mem_rdata : 32'h0BAD_0000 + 32'(mcnt);
         mcnt++;
      end
   end

   // ---------------- reference model ----------------
   // On each grant the whole transaction is scheduled: the bus is owned from the
   // grant cycle until the completion cycle, then one idle cycle precedes the next grant.
   bit          mdl_idle = 1'b1;
   bit          mdl_own_d = 1'b0;
   bit          mdl_err = 1'b0;
   int          mdl_done = -10;
   int          mdl_burst = 0;
   logic        mdl_we = 1'b0;
   logic [3:0]  mdl_sel = '0;
   logic [31:0] mdl_addr = '0;
   logic [31:0] mdl_wdata = '0;
   logic [31:0] mdl_rdata = '0;

   always @(posedge clk) begin
      n++;
      if (!rst) begin
         mdl_idle = 1'b1; mdl_burst = 0; mdl_done = -10;
         mdl_we = 1'b0; mdl_sel = '0; mdl_addr = '0; mdl_wdata = '0;
      end else if (mdl_idle) begin
         if (d_req || if_req) begin
            mdl_own_d = d_req && (!if_req || mdl_burst < MAXB);
            if (mdl_own_d) begin
               mdl_we = d_we; mdl_sel = d_sel; mdl_addr = d_addr; mdl_wdata = d_wdata;
               mdl_burst = if_req ? ((mdl_burst < MAXB) ? mdl_burst + 1 : MAXB) : 0;
            end else begin
               mdl_we = 1'b0; mdl_sel = 4'hF; mdl_addr = if_addr; mdl_wdata = '0;
               mdl_burst = 0;
            end
            mdl_err   = (mem_lat < 0) || (mem_lat >= TMO);
            mdl_done  = mdl_err ? n + TMO : n + mem_lat + 1;
            mdl_rdata = mdl_err ? 32'h0 : mem_rdata;
            mdl_idle  = 1'b0;
         end
      end else if (n == mdl_done + 1) begin
         mdl_idle = 1'b1;
      end
   end

   // ---------------- per-cycle comparison ----------------
   always @(posedge clk) begin
      #1;
      begin
         logic e_mreq, e_ifack, e_dack, e_err;
         e_mreq  = !mdl_idle && (n < mdl_done);
         e_ifack = !mdl_idle && (n == mdl_done) && !mdl_own_d;
         e_dack  = !mdl_idle && (n == mdl_done) && mdl_own_d;
         e_err   = !mdl_idle && (n == mdl_done) && mdl_err;
         chk1("m_req", m_req, e_mreq);
         chk1("if_ack", if_ack, e_ifack);
         chk1("d_ack", d_ack, e_dack);
         chk1("bus_err", bus_err, e_err);
         chk1("stall_req", stall_req, (if_req & ~e_ifack) | (d_req & ~e_dack));
         chk1("m_we", m_we, mdl_we);
         chk32("m_sel", 32'(m_sel), 32'(mdl_sel));
         chk32("m_addr", m_addr, mdl_addr);
         chk32("m_wdata", m_wdata, mdl_wdata);
         if (e_ifack) chk32("if_rdata", if_rdata, mdl_rdata);
         if (e_dack)  chk32("d_rdata", d_rdata, mdl_rdata);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_ack(input bit want_d, input bit drop, output int at);
      at = -1;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (want_d ? d_ack : if_ack) begin
            at = n;
            if (drop) begin
               if (want_d) d_req = 1'b0;
               else        if_req = 1'b0;
            end
            break;
         end
      end
      if (at < 0) chk1("wait_ack_bound", 1'b0, 1'b1);
   endtask

   initial begin
      int t0, at, a1, a2, g, acks;
      string order;

      // Reset state
      repeat (3) tick();
      chk1("rst_m_req", m_req, 1'b0);
      chk1("rst_if_ack", if_ack, 1'b0);
      chk1("rst_d_ack", d_ack, 1'b0);
      chk32("rst_m_addr", m_addr, 32'h0);
      rst = 1'b1;
      tick();

      // 1: IF read, memory answers 2 cycles after m_req
      mem_lat = 2; mem_rdata = 32'h3C010001;
      if_addr = 32'h100; if_req = 1'b1; t0 = n;
      wait_ack(1'b0, 1'b1, at);
      chk32("t1_latency", 32'(at - t0), 32'd4);
      chk32("t1_if_rdata", if_rdata, 32'h3C010001);
      chk1("t1_bus_err", bus_err, 1'b0);
      chk32("t1_m_addr", m_addr, 32'h100);
      chk32("t1_m_sel", 32'(m_sel), 32'hF);
      $display("txn1 IF read addr=%h rdata=%h ack_cycle=%0d", m_addr, if_rdata, at);

      // 2: both requesting continuously, instant memory
      tick();
      mem_lat = 0; mem_rdata = 32'h11110000;
      d_we = 1'b0; d_sel = 4'hF; d_addr = 32'h80; if_addr = 32'h104;
      if_req = 1'b1; d_req = 1'b1;
      order = "";
      for (int k = 0; k < 6; k++) begin
         at = -1;
         for (int i = 0; i < 50 && at < 0; i++) begin
            tick();
            if (d_ack || if_ack) begin
               at = n;
               order = {order, d_ack ? "D" : "I"};
            end
         end
         if (at < 0) chk1("t2_ack_bound", 1'b0, 1'b1);
      end
      if_req = 1'b0; d_req = 1'b0;
      total++;
      if (order == "DDDDID") passes++;
      else $display("FAIL t2_grant_order: got %s expected DDDDID", order);
      $display("txn2 grant order %s", order);

      // 3: D write; address changed after grant must not reach the bus
      tick();
      mem_lat = 3; mem_rdata = 32'h12345678;
      d_we = 1'b1; d_sel = 4'b0011; d_addr = 32'h40; d_wdata = 32'hDEADBEEF; d_req = 1'b1;
      tick(); tick();
      d_addr = 32'h44; d_wdata = 32'h0;
      wait_ack(1'b1, 1'b1, at);
      d_we = 1'b0;
      chk1("t3_m_we", m_we, 1'b1);
      chk32("t3_m_addr", m_addr, 32'h40);
      chk32("t3_m_wdata", m_wdata, 32'hDEADBEEF);
      chk32("t3_m_sel", 32'(m_sel), 32'h3);
      chk32("t3_d_rdata", d_rdata, 32'h12345678);
      $display("txn3 D write addr=%h wdata=%h sel=%h ack_cycle=%0d", m_addr, m_wdata, m_sel, at);

      // 4: silent memory -> forced error completion
      tick();
      mem_lat = -1; if_addr = 32'h200; if_req = 1'b1;
      g = -1;
      for (int i = 0; i < 20 && g < 0; i++) begin
         tick();
         if (m_req) g = n;
      end
      wait_ack(1'b0, 1'b1, at);
      chk32("t4_timeout_cycles", 32'(at - g), 32'd64);
      chk1("t4_bus_err", bus_err, 1'b1);
      chk32("t4_if_rdata", if_rdata, 32'h0);
      chk1("t4_m_req", m_req, 1'b0);
      $display("txn4 IF timeout grant=%0d ack=%0d bus_err=%b", g, at, bus_err);

      // 5: reset during a D grant, then a stray m_ack
      tick();
      mem_lat = -1; d_addr = 32'h300; d_req = 1'b1;
      repeat (4) tick();
      chk1("t5_granted", m_req, 1'b1);
      rst = 1'b0; d_req = 1'b0;
      tick();
      chk1("t5_m_req", m_req, 1'b0);
      chk1("t5_d_ack", d_ack, 1'b0);
      chk1("t5_bus_err", bus_err, 1'b0);
      chk32("t5_m_addr", m_addr, 32'h0);
      chk32("t5_d_rdata", d_rdata, 32'h0);
      chk1("t5_stall", stall_req, 1'b0);
      rst = 1'b1;
      force_ack = 1'b1;
      acks = 0;
      repeat (5) begin
         tick();
         if (if_ack || d_ack) acks++;
      end
      force_ack = 1'b0;
      chk32("t5_stray_acks", 32'(acks), 32'd0);
      $display("txn5 reset mid-grant, stray acks=%0d", acks);

      // 6: request held through completion -> back-to-back transactions
      tick();
      mem_lat = 1; mem_rdata = 32'h55AA55AA; if_addr = 32'h400; if_req = 1'b1;
      wait_ack(1'b0, 1'b0, a1);
      wait_ack(1'b0, 1'b0, a2);
      if_req = 1'b0;
      chk32("t6_ack_spacing", 32'(a2 - a1), 32'd4);
      $display("txn6 back-to-back IF acks at %0d and %0d", a1, a2);

      repeat (3) tick();
      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
